// File: rtl/pipeline_pkg.sv
// Shared decode constants and types for the 5-stage pipeline control logic.
package pipeline_pkg;

  // Instruction field positions
  localparam int unsigned OPC_HI = 31;
  localparam int unsigned OPC_LO = 27;
  localparam int unsigned RD_HI  = 26;
  localparam int unsigned RD_LO  = 22;
  localparam int unsigned RS_HI  = 21;
  localparam int unsigned RS_LO  = 17;
  localparam int unsigned RT_HI  = 16;
  localparam int unsigned RT_LO  = 12;
  localparam int unsigned ALU_HI = 6;
  localparam int unsigned ALU_LO = 2;

  // Opcodes
  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  // R-type ALU ops handled by the multdiv unit
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  // Multdiv occupancy FSM
  typedef enum logic {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/hazard_reg_usage.sv
// Combinational decode of which registers an instruction reads and writes,
// as seen by the hazard logic.
module hazard_reg_usage
  import pipeline_pkg::*;
(
  input  logic [31:0] instr,
  output logic        src_a_vld,
  output logic [4:0]  src_a,
  output logic        src_b_vld,
  output logic [4:0]  src_b,
  output logic [4:0]  dest_reg,
  output logic        is_lw,
  output logic        is_muldiv
);

  logic [4:0] opcode;
  logic [4:0] f_rd;
  logic [4:0] f_rs;
  logic [4:0] f_rt;
  logic [4:0] alu_op;
  logic       unused_instr_bits;

  assign opcode = instr[OPC_HI:OPC_LO];
  assign f_rd   = instr[RD_HI:RD_LO];
  assign f_rs   = instr[RS_HI:RS_LO];
  assign f_rt   = instr[RT_HI:RT_LO];
  assign alu_op = instr[ALU_HI:ALU_LO];

  // Shamt and low bits play no part in hazard detection
  assign unused_instr_bits = ^{instr[11:7], instr[1:0]};

  assign dest_reg  = f_rd;
  assign is_lw     = (opcode == OP_LW);
  assign is_muldiv = (opcode == OP_RTYPE) && ((alu_op == ALU_MUL) || (alu_op == ALU_DIV));

  // Select source registers per opcode class; r0 is never a real dependency
  always_comb begin
    src_a_vld = 1'b0;
    src_a     = '0;
    src_b_vld = 1'b0;
    src_b     = '0;
    case (opcode)
      OP_RTYPE: begin
        src_a_vld = 1'b1;
        src_a     = f_rs;
        src_b_vld = 1'b1;
        src_b     = f_rt;
      end
      OP_BNE, OP_BLT: begin
        src_a_vld = 1'b1;
        src_a     = f_rd;
        src_b_vld = 1'b1;
        src_b     = f_rs;
      end
      OP_JR: begin
        src_a_vld = 1'b1;
        src_a     = f_rd;
      end
      OP_J, OP_JAL, OP_SETX, OP_BEX: begin
        src_a_vld = 1'b0;
      end
      default: begin
        // I-type ALU, lw, and sw: sw store data (rd) arrives via the W bypass,
        // so only the base register is a load-use source
        src_a_vld = 1'b1;
        src_a     = f_rs;
      end
    endcase
    if (src_a == '0) src_a_vld = 1'b0;
    if (src_b == '0) src_b_vld = 1'b0;
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller: load-use stalls, multdiv freeze of X, and
// taken-branch squashes; also sequences the multdiv start/done handshake.
module hazard_stall_unit
  import pipeline_pkg::*;
#(
  parameter int unsigned MD_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      IR_D,
  input  logic [31:0]      IR_X,
  input  logic             branch_taken,
  input  logic             md_ready,
  output logic             pc_we,
  output logic             fd_we,
  output logic             fd_flush,
  output logic             dx_we,
  output logic             dx_nop,
  output logic             xm_nop,
  output logic             md_start,
  output logic             md_done,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_count
);

  localparam int unsigned     TO_W    = $clog2(MD_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(MD_TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MD_TIMEOUT - 1);

  md_state_e        state_q, state_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             md_timeout_q, md_timeout_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic             freeze;
  logic             load_use;

  logic             d_a_vld, d_b_vld;
  logic [4:0]       d_a, d_b, d_dest;
  logic             d_is_lw, d_is_muldiv;
  logic             x_a_vld, x_b_vld;
  logic [4:0]       x_a, x_b, x_dest;
  logic             x_is_lw, x_is_muldiv;
  logic             unused_usage;

  hazard_reg_usage u_use_d (
    .instr     (IR_D),
    .src_a_vld (d_a_vld),
    .src_a     (d_a),
    .src_b_vld (d_b_vld),
    .src_b     (d_b),
    .dest_reg  (d_dest),
    .is_lw     (d_is_lw),
    .is_muldiv (d_is_muldiv)
  );

  hazard_reg_usage u_use_x (
    .instr     (IR_X),
    .src_a_vld (x_a_vld),
    .src_a     (x_a),
    .src_b_vld (x_b_vld),
    .src_b     (x_b),
    .dest_reg  (x_dest),
    .is_lw     (x_is_lw),
    .is_muldiv (x_is_muldiv)
  );

  // D only contributes reads, X only its destination and class
  assign unused_usage = ^{d_dest, d_is_lw, d_is_muldiv, x_a_vld, x_a, x_b_vld, x_b};

  assign load_use = x_is_lw && (x_dest != '0) &&
                    ((d_a_vld && (d_a == x_dest)) || (d_b_vld && (d_b == x_dest)));

  assign md_timeout  = md_timeout_q;
  assign stall_count = stall_count_q;

  // FSM next state and prioritized pipeline control: reset > freeze > branch > load-use
  always_comb begin
    pc_we        = 1'b1;
    fd_we        = 1'b1;
    dx_we        = 1'b1;
    fd_flush     = 1'b0;
    dx_nop       = 1'b0;
    xm_nop       = 1'b0;
    md_start     = 1'b0;
    md_done      = 1'b0;
    freeze       = 1'b0;
    state_d      = state_q;
    to_cnt_d     = to_cnt_q;
    md_timeout_d = md_timeout_q;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (x_is_muldiv) begin
            md_start = 1'b1;
            freeze   = 1'b1;
            state_d  = MD_BUSY;
            to_cnt_d = '0;
          end
        end
        MD_BUSY: begin
          if (md_ready) begin
            md_done = 1'b1;
            state_d = IDLE;
          end else begin
            freeze = 1'b1;
            if (to_cnt_q != TO_MAX) to_cnt_d = to_cnt_q + TO_W'(1);
            if (to_cnt_q >= TO_LAST) md_timeout_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase

      if (freeze) begin
        pc_we  = 1'b0;
        fd_we  = 1'b0;
        dx_we  = 1'b0;
        xm_nop = 1'b1;
      end else if (branch_taken) begin
        fd_flush = 1'b1;
        dx_nop   = 1'b1;
      end else if (load_use) begin
        pc_we  = 1'b0;
        fd_we  = 1'b0;
        dx_nop = 1'b1;
      end
    end
  end

  // Performance counter: one count per cycle the PC is held
  always_comb begin
    stall_count_d = stall_count_q;
    if (!pc_we) stall_count_d = stall_count_q + CNT_W'(1);
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      to_cnt_q      <= '0;
      md_timeout_q  <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      to_cnt_q      <= to_cnt_d;
      md_timeout_q  <= md_timeout_d;
      stall_count_q <= stall_count_d;
    end
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Stall and flush controller for the 5-stage pipeline. It handles every hazard the forwarding network cannot resolve: load-use dependencies, multi-cycle mul/div occupancy of X, and taken-branch/jump squashes.
- It sits beside the bypass network and drives the write-enables and NOP-insert selects of the PC, F/D, D/X and X/M latches.
- It also starts the multdiv unit and reports its completion and timeout.

Parameters:
- MD_TIMEOUT, 64, max cycles in MD_BUSY before md_timeout is raised.
- CNT_W, 32, width of the stall_count performance counter.

Ports:
- clock  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- IR_D  in  32  instruction in F/D latch
- IR_X  in  32  instruction in D/X latch
- branch_taken  in  1  X-stage taken branch/jump/jr/bex
- md_ready  in  1  multdiv result valid
- pc_we  out  1  PC write enable
- fd_we  out  1  F/D latch write enable
- fd_flush  out  1  load NOP into F/D
- dx_we  out  1  D/X latch write enable
- dx_nop  out  1  load NOP into D/X
- xm_nop  out  1  load NOP into X/M
- md_start  out  1  one-cycle multdiv start pulse
- md_done  out  1  X/M captures multdiv result this cycle
- md_timeout  out  1  sticky error
- stall_count  out  CNT_W  cycles with pc_we=0, wraps

Behaviour:
Decode rules:
- opcode = [31:27], rd = [26:22], rs = [21:17], rt = [16:12], ALU op = [6:2].
- lw = 01000. sw = 00111. mul/div = opcode 00000 with ALU op 00110/00111.

Register reads of IR_D:
- R-type: rs and rt.
- I-type ALU/lw: rs.
- sw: rs as the address only. Its data in rd is forwarded from W, so it is not a load-use source.
- bne/blt (00010/00110): rd and rs.
- jr (00100): rd.
- j/jal/setx/bex: none (bex's r30 dependency is forwarded).
- Register 0 never matches.

load_use condition:
- IR_X is lw with rd != 0, and rd equals a read register of IR_D.
- Response is a 1-cycle stall: pc_we=0, fd_we=0, dx_nop=1, dx_we=1.

FSM states: IDLE, MD_BUSY.

IDLE:
- If IR_X is mul/div: md_start=1, freeze (pc_we=fd_we=dx_we=0, xm_nop=1), next state MD_BUSY, timeout counter cleared.
- md_ready is ignored in IDLE.

MD_BUSY:
- While md_ready=0: freeze, and the timeout counter increments.
- If the counter reaches MD_TIMEOUT: set md_timeout (sticky until reset) and stay frozen.
- When md_ready=1: md_done=1, all enables 1, xm_nop=0, next state IDLE.
- A back-to-back mul in the new IR_X restarts from IDLE the next cycle. md_start is never reissued for the same instruction.

Priority, evaluated combinationally each cycle:
1. reset: all enables 1, all nop/flush/start/done 0.
2. MD freeze (start cycle or MD_BUSY without ready).
3. branch_taken: fd_flush=1, dx_nop=1, enables 1.
4. load_use.
5. Default: enables 1, others 0.
- branch_taken is don't-care while frozen, because X holds the mul.
- load_use is suppressed while frozen and re-evaluated on release.
- Branch + load_use in the same cycle: the flush wins, since the dependent instruction is squashed.

Registers:
- state, timeout counter, md_timeout and stall_count are registered.
- reset (synchronous) forces IDLE, 0, 0, 0.
- Reset in MD_BUSY abandons the operation on the next edge.

stall_count:
- Increments on every edge where pc_we=0 and reset=0.
- Wraps modulo 2^CNT_W.

Decomposition:
- Shared package pipeline_pkg holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BNE, OP_BLT, OP_JR, OP_J, OP_JAL, OP_BEX, OP_SETX;
  - ALU op constants ALU_MUL, ALU_DIV;
  - the FSM state enum;
  - field-slice ranges.
- One sub-module, hazard_reg_usage: combinational. Takes an instruction and outputs read-register set valid bits plus indices, dest-register, is_lw and is_muldiv.
- Instantiate hazard_reg_usage twice, once for IR_D and once for IR_X.

Test Plan:
- IR_X = lw r5,0(r2); IR_D = add r7,r5,r3 -> one cycle pc_we=0, fd_we=0, dx_nop=1. Next cycle, with IR_X=NOP, enables return to 1. stall_count=1.
- IR_X = lw r0,0(r2); IR_D = add r7,r0,r0 -> no stall. Also IR_X = lw r5; IR_D = sw r5,4(r6) -> no stall.
- IR_X = mul r4,r1,r2 with md_ready asserted 17 cycles after start -> md_start high for exactly 1 cycle, 17 frozen cycles with xm_nop=1, md_done=1 on the ready cycle, then IDLE. stall_count=17.
- branch_taken=1 while IR_X = lw r5 and IR_D = add r7,r5,r3 -> fd_flush=1, dx_nop=1, pc_we=1, no stall.
- mul in X with md_ready held 0 and MD_TIMEOUT=64 -> md_timeout rises after 64 busy cycles and stays high. Reset pulse -> IDLE, md_timeout=0, stall_count=0.
- Reset asserted on the 3rd MD_BUSY cycle -> next cycle state IDLE with all enables 1. A later md_ready pulse while IDLE produces no md_done.
